pipeline_debug_ctrl: RTL and testbench
======================================

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 The block SHALL have parameter N_REGS, default 32, the number of register-file words dumped.
REQ-002 The block SHALL have parameter N_MEM_WORDS, default 32, the number of data-memory words dumped, from byte address 0 in steps of 4.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_rx_data, input, 8 bits: command/payload byte from the host link.
REQ-006 The block SHALL have ports i_rx_valid (input, 1) and o_rx_ready (output, 1): a byte is consumed when both are high on a clock edge.
REQ-007 The block SHALL have port o_tx_data, output, 8 bits: response byte to the host link.
REQ-008 The block SHALL have ports o_tx_valid (output, 1) and i_tx_ready (input, 1): a byte is sent when both are high on a clock edge.
REQ-009 The block SHALL have port o_halt, output, 1 bit: freezes the pipeline when high.
REQ-010 The block SHALL have port o_write_instruction_flag, output, 1 bit: instruction-memory write strobe.
REQ-011 The block SHALL have ports o_instruction_to_write and o_address_to_write_inst, outputs, 32 bits each: instruction word and its byte address.
REQ-012 The block SHALL have ports o_reg_read (output, 5 bits) and i_reg_content (input, 32 bits): register-file debug read.
REQ-013 The block SHALL have ports o_addr_to_read_mem_data (output, 32 bits) and i_mem_addr_content (input, 32 bits): data-memory debug read.
REQ-014 The block SHALL have port i_program_end, input, 1 bit: the pipeline has retired its end-of-program instruction.

Function
REQ-015 States SHALL be: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_ADDR, DUMP_CAP, DUMP_SEND and RESP.
REQ-016 o_rx_ready SHALL be high only in IDLE, LOAD_CNT and LOAD_BYTE.
REQ-017 o_halt SHALL be high in every state except RUN and STEP.
REQ-018 In IDLE, byte 0x4C ('L') SHALL go to LOAD_CNT, 0x43 ('C') to RUN, and 0x53 ('S') to STEP.
REQ-019 In IDLE, any other byte SHALL be consumed and answered with response byte 0x3F through RESP.
REQ-020 LOAD_CNT SHALL capture count N from 1 byte; N=0 SHALL go directly to RESP with 0x06.
REQ-021 LOAD_BYTE SHALL shift in 4 bytes per word, MSB first.
REQ-022 After the 4th byte, LOAD_WRITE SHALL drive o_write_instruction_flag high for exactly 1 cycle, with address = 4*k (k = word index from 0) and the assembled word.
REQ-023 After a LOAD_WRITE, the block SHALL return to LOAD_BYTE, or to RESP with 0x06 once k = N-1.
REQ-024 RUN SHALL hold o_halt low until i_program_end is sampled high, then enter DUMP_ADDR with o_halt high on the next cycle.
REQ-025 If i_program_end is already high on entry to RUN, the block SHALL halt after 1 cycle.
REQ-026 STEP SHALL hold o_halt low for exactly 1 cycle, then enter DUMP_ADDR.
REQ-027 The dump SHALL send N_REGS register words (index 0..N_REGS-1), then N_MEM_WORDS memory words (address 0,4,...), each word as 4 bytes MSB first.
REQ-028 DUMP_ADDR SHALL drive the index or address; DUMP_CAP SHALL register the read data 1 cycle later; DUMP_SEND SHALL emit the 4 bytes.
REQ-029 After the last dump byte, the block SHALL return to IDLE.
REQ-030 o_tx_valid SHALL stay high with o_tx_data stable until i_tx_ready; there is no timeout, and a stalled i_tx_ready blocks indefinitely.
REQ-031 RESP SHALL send one byte under the same valid/ready rule, then return to IDLE.
REQ-032 Word counters SHALL be wide enough for 255 words (load) and N_REGS+N_MEM_WORDS words (dump); byte counters SHALL be 2 bits and wrap 3->0 per word.
REQ-033 When not in use, o_addr_to_read_mem_data and o_reg_read SHALL hold their last values, and o_instruction_to_write/o_address_to_write_inst SHALL hold their last written values.

Reset
REQ-034 On i_reset high at a clock edge, the block SHALL go to IDLE in any state, including mid-load and mid-dump.
REQ-035 Reset values SHALL be: o_halt=1, o_rx_ready=1, o_tx_valid=0, o_tx_data=0, o_write_instruction_flag=0, all address/data/index outputs=0, all counters=0.
REQ-036 A partial word or dump in progress at reset SHALL be discarded with no further tx bytes.

Structure
REQ-037 Command codes (0x4C, 0x43, 0x53), response codes (0x06, 0x3F) and the state encoding SHALL live in a shared package pipeline_debug_pkg.
REQ-038 A single sub-module, debug_word_serializer, SHALL implement 32-bit-to-4-byte MSB-first transmission with valid/ready.
REQ-039 The block SHALL implement a single FSM with registered outputs.

Verification
REQ-040 Bench SHALL cover: reset -> o_halt=1, o_tx_valid=0, o_rx_ready=1, state IDLE.
REQ-041 Bench SHALL cover: 'L', 0x02, 12 34 56 78, DE AD BE EF -> one-cycle write pulses at addr 0 with data 0x12345678 and at addr 4 with data 0xDEADBEEF, then tx byte 0x06.
REQ-042 Bench SHALL cover: 'S' with i_reg_content=0xA5A5A5A5 for all indices -> o_halt low exactly 1 cycle, then 256 tx bytes (default parameters) beginning A5 A5 A5 A5.
REQ-043 Bench SHALL cover: 'C' with i_program_end asserted 10 cycles later -> o_halt low for 10 cycles, then dump; i_tx_ready toggling every other cycle loses and duplicates no bytes.
REQ-044 Bench SHALL cover: byte 0x7A in IDLE -> single tx byte 0x3F, pipeline untouched.
REQ-045 Bench SHALL cover: reset asserted after the 2nd payload byte of a load -> no write pulse, IDLE, and a following 'L', 0x00 returns 0x06.

Source files
------------

// File: rtl/pipeline_debug_pkg.sv
// Shared command/response codes and FSM state encoding for the pipeline debug controller.
package pipeline_debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_RUN,
        ST_STEP,
        ST_DUMP_ADDR,
        ST_DUMP_CAP,
        ST_DUMP_SEND,
        ST_RESP
    } state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// Sends one captured 32-bit word as four bytes, MSB first, over a valid/ready link.
module debug_word_serializer (
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic [31:0] word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        last_beat
);

    logic [31:0] word_reg;
    logic [1:0]  byte_cnt_reg;
    logic        valid_reg;
    logic [7:0]  lane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word_reg[31-8*gi -: 8];
        end
    endgenerate

    // Data is taken straight from the held word, so it stays stable while stalled.
    assign tx_data   = lane[byte_cnt_reg];
    assign tx_valid  = valid_reg;
    assign last_beat = valid_reg && tx_ready && (byte_cnt_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (srst) begin
            word_reg     <= '0;
            byte_cnt_reg <= '0;
            valid_reg    <= 1'b0;
        end else if (load && !valid_reg) begin
            word_reg     <= word;
            byte_cnt_reg <= '0;
            valid_reg    <= 1'b1;
        end else if (valid_reg && tx_ready) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
                valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Host-link debug controller: loads instruction memory, runs or steps the pipeline,
// then dumps register file and data memory back to the host.
module pipeline_debug_ctrl
    import pipeline_debug_pkg::*;
#(
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_halt,
    output logic        o_write_instruction_flag,
    output logic [31:0] o_instruction_to_write,
    output logic [31:0] o_address_to_write_inst,
    output logic [4:0]  o_reg_read,
    input  logic [31:0] i_reg_content,
    output logic [31:0] o_addr_to_read_mem_data,
    input  logic [31:0] i_mem_addr_content,
    input  logic        i_program_end
);

    localparam int DUMP_WORDS = N_REGS + N_MEM_WORDS;
    localparam int DUMP_W     = $clog2(DUMP_WORDS + 1);
    localparam logic [DUMP_W-1:0] N_REGS_W    = DUMP_W'(N_REGS);
    localparam logic [DUMP_W-1:0] LAST_DUMP_W = DUMP_W'(DUMP_WORDS - 1);

    state_t             state_reg;
    logic               halt_reg;
    logic               rx_ready_reg;
    logic               wr_flag_reg;
    logic [31:0]        inst_reg;
    logic [31:0]        inst_addr_reg;
    logic [4:0]         reg_read_reg;
    logic [31:0]        mem_addr_reg;
    logic [7:0]         load_total_reg;
    logic [7:0]         load_idx_reg;
    logic [1:0]         load_byte_reg;
    logic [23:0]        load_shift_reg;
    logic [DUMP_W-1:0]  dump_idx_reg;
    logic               resp_valid_reg;
    logic [7:0]         resp_data_reg;

    logic               rx_fire;
    logic               ser_load;
    logic [31:0]        ser_word;
    logic [7:0]         ser_data;
    logic               ser_valid;
    logic               ser_last;
    logic               dump_last_word;
    logic               enter_dump;
    logic [DUMP_W-1:0]  dump_next_idx;
    logic [DUMP_W-1:0]  mem_word_idx;

    assign rx_fire        = i_rx_valid && rx_ready_reg;
    assign dump_last_word = (dump_idx_reg == LAST_DUMP_W);
    assign ser_load       = (state_reg == ST_DUMP_CAP);
    assign ser_word       = (dump_idx_reg < N_REGS_W) ? i_reg_content : i_mem_addr_content;

    // Any transition into DUMP_ADDR: the first word after RUN/STEP, or the next word after a send.
    assign enter_dump = ((state_reg == ST_RUN) && i_program_end) ||
                        (state_reg == ST_STEP) ||
                        ((state_reg == ST_DUMP_SEND) && ser_last && !dump_last_word);
    assign dump_next_idx = (state_reg == ST_DUMP_SEND) ? dump_idx_reg + DUMP_W'(1) : '0;
    assign mem_word_idx  = dump_next_idx - N_REGS_W;

    debug_word_serializer u_serializer (
        .clk       (i_clk),
        .srst      (i_reset),
        .load      (ser_load),
        .word      (ser_word),
        .tx_data   (ser_data),
        .tx_valid  (ser_valid),
        .tx_ready  (i_tx_ready),
        .last_beat (ser_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= ST_IDLE;
            halt_reg       <= 1'b1;
            rx_ready_reg   <= 1'b1;
            wr_flag_reg    <= 1'b0;
            inst_reg       <= '0;
            inst_addr_reg  <= '0;
            reg_read_reg   <= '0;
            mem_addr_reg   <= '0;
            load_total_reg <= '0;
            load_idx_reg   <= '0;
            load_byte_reg  <= '0;
            load_shift_reg <= '0;
            dump_idx_reg   <= '0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else begin
            wr_flag_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_fire) begin
                        case (i_rx_data)
                            CMD_LOAD: state_reg <= ST_LOAD_CNT;
                            CMD_CONT: begin
                                state_reg    <= ST_RUN;
                                halt_reg     <= 1'b0;
                                rx_ready_reg <= 1'b0;
                            end
                            CMD_STEP: begin
                                state_reg    <= ST_STEP;
                                halt_reg     <= 1'b0;
                                rx_ready_reg <= 1'b0;
                            end
                            default: begin
                                state_reg      <= ST_RESP;
                                rx_ready_reg   <= 1'b0;
                                resp_valid_reg <= 1'b1;
                                resp_data_reg  <= RSP_ERR;
                            end
                        endcase
                    end
                end
                ST_LOAD_CNT: begin
                    if (rx_fire) begin
                        load_total_reg <= i_rx_data;
                        load_idx_reg   <= '0;
                        load_byte_reg  <= '0;
                        if (i_rx_data == 8'd0) begin
                            state_reg      <= ST_RESP;
                            rx_ready_reg   <= 1'b0;
                            resp_valid_reg <= 1'b1;
                            resp_data_reg  <= RSP_ACK;
                        end else begin
                            state_reg <= ST_LOAD_BYTE;
                        end
                    end
                end
                ST_LOAD_BYTE: begin
                    if (rx_fire) begin
                        load_byte_reg  <= load_byte_reg + 2'd1;
                        load_shift_reg <= {load_shift_reg[15:0], i_rx_data};
                        if (load_byte_reg == 2'd3) begin
                            state_reg     <= ST_LOAD_WRITE;
                            rx_ready_reg  <= 1'b0;
                            wr_flag_reg   <= 1'b1;
                            inst_reg      <= {load_shift_reg, i_rx_data};
                            inst_addr_reg <= {22'd0, load_idx_reg, 2'b00};
                        end
                    end
                end
                ST_LOAD_WRITE: begin
                    if (load_idx_reg == load_total_reg - 8'd1) begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_data_reg  <= RSP_ACK;
                    end else begin
                        load_idx_reg <= load_idx_reg + 8'd1;
                        state_reg    <= ST_LOAD_BYTE;
                        rx_ready_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_program_end) begin
                        state_reg <= ST_DUMP_ADDR;
                        halt_reg  <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_reg <= ST_DUMP_ADDR;
                    halt_reg  <= 1'b1;
                end
                ST_DUMP_ADDR: state_reg <= ST_DUMP_CAP;
                ST_DUMP_CAP:  state_reg <= ST_DUMP_SEND;
                ST_DUMP_SEND: begin
                    if (ser_last) begin
                        if (dump_last_word) begin
                            state_reg    <= ST_IDLE;
                            rx_ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_DUMP_ADDR;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_tx_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                        rx_ready_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    halt_reg     <= 1'b1;
                    rx_ready_reg <= 1'b1;
                end
            endcase

            // Only the address for the active region moves; the other keeps its last value.
            if (enter_dump) begin
                dump_idx_reg <= dump_next_idx;
                if (dump_next_idx < N_REGS_W) begin
                    reg_read_reg <= 5'(dump_next_idx);
                end else begin
                    mem_addr_reg <= 32'(mem_word_idx) << 2;
                end
            end
        end
    end

    assign o_rx_ready               = rx_ready_reg;
    assign o_halt                   = halt_reg;
    assign o_tx_valid               = ser_valid || resp_valid_reg;
    assign o_tx_data                = resp_valid_reg ? resp_data_reg : ser_data;
    assign o_write_instruction_flag = wr_flag_reg;
    assign o_instruction_to_write   = inst_reg;
    assign o_address_to_write_inst  = inst_addr_reg;
    assign o_reg_read               = reg_read_reg;
    assign o_addr_to_read_mem_data  = mem_addr_reg;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Directed bench for pipeline_debug_ctrl: load, step, continue, bad command and mid-load reset.
module tb_pipeline_debug_ctrl;
    import pipeline_debug_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_halt;
    logic        o_write_instruction_flag;
    logic [31:0] o_instruction_to_write;
    logic [31:0] o_address_to_write_inst;
    logic [4:0]  o_reg_read;
    logic [31:0] i_reg_content;
    logic [31:0] o_addr_to_read_mem_data;
    logic [31:0] i_mem_addr_content;
    logic        i_program_end = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          halt_low_total = 0;
    int          stall_err = 0;
    logic        tx_toggle = 1'b0;
    logic        reg_const = 1'b0;
    logic        pending = 1'b0;
    logic [7:0]  last_data = 8'h00;

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] reg_model(input logic [4:0] r);
        return {3'b000, r, 8'hA1, 3'b000, r, 8'h5E};
    endfunction

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'h6B2D_0F00;
    endfunction

    assign i_reg_content      = reg_const ? 32'hA5A5_A5A5 : reg_model(o_reg_read);
    assign i_mem_addr_content = mem_model(o_addr_to_read_mem_data);

    pipeline_debug_ctrl dut (
        .i_clk                    (i_clk),
        .i_reset                  (i_reset),
        .i_rx_data                (i_rx_data),
        .i_rx_valid               (i_rx_valid),
        .o_rx_ready               (o_rx_ready),
        .o_tx_data                (o_tx_data),
        .o_tx_valid               (o_tx_valid),
        .i_tx_ready               (i_tx_ready),
        .o_halt                   (o_halt),
        .o_write_instruction_flag (o_write_instruction_flag),
        .o_instruction_to_write   (o_instruction_to_write),
        .o_address_to_write_inst  (o_address_to_write_inst),
        .o_reg_read               (o_reg_read),
        .i_reg_content            (i_reg_content),
        .o_addr_to_read_mem_data  (o_addr_to_read_mem_data),
        .i_mem_addr_content       (i_mem_addr_content),
        .i_program_end            (i_program_end)
    );

    // Link monitor: sets tx_ready for the coming edge, then records what that edge will transfer.
    always @(negedge i_clk) begin
        if (tx_toggle) i_tx_ready = ~i_tx_ready;
        else           i_tx_ready = 1'b1;
        if (pending && (!o_tx_valid || o_tx_data != last_data)) stall_err++;
        if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
        pending   = o_tx_valid && !i_tx_ready;
        last_data = o_tx_data;
        if (o_write_instruction_flag) begin
            wr_addr_q.push_back(o_address_to_write_inst);
            wr_data_q.push_back(o_instruction_to_write);
        end
        if (!o_halt) halt_low_total++;
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (o_rx_ready) begin
                ok = 1;
                @(negedge i_clk);
                break;
            end
            @(negedge i_clk);
        end
        i_rx_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rx_accept: byte %h got not-accepted required accepted", b);
        end
    endtask

    task automatic wait_tx(input int target, input int budget);
        for (int i = 0; i < budget && tx_q.size() < target; i++) @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL reset_halt: got %b required 1", o_halt); end
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b required 0", o_tx_valid); end
        checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b required 1", o_rx_ready); end
        checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dut.state_reg, ST_IDLE); end
        checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", o_tx_data); end
        checks++; if (o_write_instruction_flag !== 1'b0) begin errors++; $display("FAIL reset_wr_flag: got %b required 0", o_write_instruction_flag); end
        checks++; if (o_address_to_write_inst !== 32'h0) begin errors++; $display("FAIL reset_wr_addr: got %h required 0", o_address_to_write_inst); end
        checks++; if (o_reg_read !== 5'd0) begin errors++; $display("FAIL reset_reg_read: got %h required 0", o_reg_read); end
        checks++; if (o_addr_to_read_mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0", o_addr_to_read_mem_data); end
        $display("reset: halt=%b rx_ready=%b tx_valid=%b", o_halt, o_rx_ready, o_tx_valid);
    endtask

    task automatic test_load();
        int tb0 = tx_q.size();
        int wb0 = wr_addr_q.size();
        logic [7:0] bytes [10];
        bytes = '{8'h4C, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 10; i++) send_byte(bytes[i]);
        wait_tx(tb0 + 1, 100);
        repeat (5) @(negedge i_clk);
        checks++; if (wr_addr_q.size() !== wb0 + 2) begin errors++; $display("FAIL load_pulses: got %0d required %0d", wr_addr_q.size() - wb0, 2); end
        if (wr_addr_q.size() >= wb0 + 2) begin
            checks++; if (wr_addr_q[wb0] !== 32'h0) begin errors++; $display("FAIL load_addr0: got %h required 00000000", wr_addr_q[wb0]); end
            checks++; if (wr_data_q[wb0] !== 32'h12345678) begin errors++; $display("FAIL load_data0: got %h required 12345678", wr_data_q[wb0]); end
            checks++; if (wr_addr_q[wb0+1] !== 32'h4) begin errors++; $display("FAIL load_addr1: got %h required 00000004", wr_addr_q[wb0+1]); end
            checks++; if (wr_data_q[wb0+1] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data1: got %h required deadbeef", wr_data_q[wb0+1]); end
        end
        checks++; if (tx_q.size() !== tb0 + 1) begin errors++; $display("FAIL load_tx_count: got %0d required 1", tx_q.size() - tb0); end
        else begin
            checks++; if (tx_q[tb0] !== RSP_ACK) begin errors++; $display("FAIL load_ack: got %h required 06", tx_q[tb0]); end
        end
        checks++; if (o_instruction_to_write !== 32'hDEADBEEF) begin errors++; $display("FAIL load_hold_data: got %h required deadbeef", o_instruction_to_write); end
        checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL load_idle: rx_ready got %b required 1", o_rx_ready); end
        $display("load: 2 words written, response sent");
    endtask

    task automatic test_step();
        int tb0 = tx_q.size();
        int n = 0;
        int bad_reg = 0;
        int bad_mem = 0;
        reg_const = 1'b1;
        send_byte(CMD_STEP);
        for (int i = 0; i < 20; i++) begin
            if (o_halt) break;
            n++;
            @(negedge i_clk);
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL step_halt_low: got %0d cycles required 1", n); end
        wait_tx(tb0 + 256, 4000);
        repeat (20) @(negedge i_clk);
        reg_const = 1'b0;
        checks++; if (tx_q.size() !== tb0 + 256) begin errors++; $display("FAIL step_tx_count: got %0d required 256", tx_q.size() - tb0); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (tx_q[tb0+k] !== 8'hA5) begin errors++; $display("FAIL step_first_byte%0d: got %h required a5", k, tx_q[tb0+k]); end
            end
            for (int k = 4; k < 128; k++) if (tx_q[tb0+k] !== 8'hA5) bad_reg++;
            for (int w = 0; w < 32; w++) begin
                logic [31:0] exp_w = mem_model(32'(w * 4));
                for (int b = 0; b < 4; b++)
                    if (tx_q[tb0+128+4*w+b] !== exp_w[31-8*b -: 8]) bad_mem++;
            end
            checks++; if (bad_reg !== 0) begin errors++; $display("FAIL step_reg_bytes: got %0d wrong bytes required 0", bad_reg); end
            checks++; if (bad_mem !== 0) begin errors++; $display("FAIL step_mem_bytes: got %0d wrong bytes required 0", bad_mem); end
        end
        checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL step_idle: rx_ready got %b required 1", o_rx_ready); end
        $display("step: halt low %0d cycle(s), %0d bytes dumped", n, tx_q.size() - tb0);
    endtask

    task automatic test_continue();
        int tb0 = tx_q.size();
        int se0 = stall_err;
        int n = 0;
        tx_toggle = 1'b1;
        send_byte(CMD_CONT);
        for (int i = 0; i < 50; i++) begin
            if (o_halt) break;
            n++;
            if (n == 10) i_program_end = 1'b1;
            @(negedge i_clk);
        end
        i_program_end = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL cont_halt_low: got %0d cycles required 10", n); end
        wait_tx(tb0 + 256, 6000);
        repeat (20) @(negedge i_clk);
        tx_toggle = 1'b0;
        checks++; if (tx_q.size() !== tb0 + 256) begin errors++; $display("FAIL cont_tx_count: got %0d required 256", tx_q.size() - tb0); end
        else begin
            for (int w = 0; w < 64; w++) begin
                logic [31:0] exp_w = (w < 32) ? reg_model(5'(w)) : mem_model(32'((w - 32) * 4));
                logic [31:0] got_w = {tx_q[tb0+4*w], tx_q[tb0+4*w+1], tx_q[tb0+4*w+2], tx_q[tb0+4*w+3]};
                checks++;
                if (got_w !== exp_w) begin errors++; $display("FAIL cont_word%0d: got %h required %h", w, got_w, exp_w); end
            end
        end
        checks++; if (stall_err !== se0) begin errors++; $display("FAIL cont_tx_stable: got %0d unstable stalls required 0", stall_err - se0); end
        checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL cont_idle: rx_ready got %b required 1", o_rx_ready); end
        $display("continue: halt low %0d cycles, %0d bytes dumped", n, tx_q.size() - tb0);
    endtask

    task automatic test_bad_cmd();
        int tb0 = tx_q.size();
        int wb0 = wr_addr_q.size();
        int hl0 = halt_low_total;
        send_byte(8'h7A);
        wait_tx(tb0 + 1, 100);
        repeat (10) @(negedge i_clk);
        checks++; if (tx_q.size() !== tb0 + 1) begin errors++; $display("FAIL bad_tx_count: got %0d required 1", tx_q.size() - tb0); end
        else begin
            checks++; if (tx_q[tb0] !== RSP_ERR) begin errors++; $display("FAIL bad_resp: got %h required 3f", tx_q[tb0]); end
        end
        checks++; if (halt_low_total !== hl0) begin errors++; $display("FAIL bad_halt: got %0d low cycles required 0", halt_low_total - hl0); end
        checks++; if (wr_addr_q.size() !== wb0) begin errors++; $display("FAIL bad_write: got %0d pulses required 0", wr_addr_q.size() - wb0); end
        $display("bad command 7a: response %h", (tx_q.size() > tb0) ? tx_q[tb0] : 8'h00);
    endtask

    task automatic test_reset_mid_load();
        int tb0 = tx_q.size();
        int wb0 = wr_addr_q.size();
        send_byte(CMD_LOAD);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d required %0d", dut.state_reg, ST_IDLE); end
        checks++; if (o_rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_rx_ready: got %b required 1", o_rx_ready); end
        checks++; if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b required 0", o_tx_valid); end
        send_byte(CMD_LOAD);
        send_byte(8'h00);
        wait_tx(tb0 + 1, 100);
        repeat (5) @(negedge i_clk);
        checks++; if (wr_addr_q.size() !== wb0) begin errors++; $display("FAIL midrst_write: got %0d pulses required 0", wr_addr_q.size() - wb0); end
        checks++; if (tx_q.size() !== tb0 + 1) begin errors++; $display("FAIL midrst_tx_count: got %0d required 1", tx_q.size() - tb0); end
        else begin
            checks++; if (tx_q[tb0] !== RSP_ACK) begin errors++; $display("FAIL midrst_ack: got %h required 06", tx_q[tb0]); end
        end
        $display("reset mid-load: partial word discarded, empty load acknowledged");
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_continue();
        test_bad_cmd();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
